// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage between execute and writeback.
//   Non-memory results are registered straight through to wb_*. Loads and
//   stores go out on a valid/ready data-memory port with byte/half/word lane
//   steering, sign/zero extension of load data, misalignment detection and a
//   response timeout. Upstream is frozen (mem_stall) while a transaction is
//   outstanding or its result is parked waiting for downstream.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   ex_*                          instruction arriving from execute
//   stall, flush                  downstream hold / kill current instruction
//   dmem_req_* / dmem_rsp_*       data-memory request and response channels
//   wb_*                          registered result towards writeback
//   mem_stall                     freeze upstream
//   misaligned_exc, timeout_exc   one-cycle exception pulses

package mem_stage_pkg;
  typedef logic [15:0] decoded_instr_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [DATA_WIDTH-1:0] ex_alu_result,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  decoded_instr_t        ex_decoded,
  input  logic [ADDR_WIDTH-1:0] ex_pc,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [1:0]            ex_mem_size,
  input  logic                  ex_mem_unsigned,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  output logic [3:0]            dmem_req_be,
  input  logic                  dmem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_rsp_rdata,
  output logic [DATA_WIDTH-1:0] wb_result,
  output decoded_instr_t        wb_decoded,
  output logic [ADDR_WIDTH-1:0] wb_pc,
  output logic                  wb_valid,
  output logic                  mem_stall,
  output logic                  misaligned_exc,
  output logic                  timeout_exc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] lane_wdata(input logic [1:0] size,
                                                       input logic [DATA_WIDTH-1:0] d);
    case (size)
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_extend(input logic [DATA_WIDTH-1:0] rdata,
                                                        input logic [1:0] off,
                                                        input logic [1:0] size,
                                                        input logic uns);
    logic [DATA_WIDTH-1:0] sh;
    logic signed [7:0]     b;
    logic signed [15:0]    h;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00: begin
        if (uns) return DATA_WIDTH'(sh[7:0]);
        return DATA_WIDTH'(b);
      end
      2'b01: begin
        if (uns) return DATA_WIDTH'(sh[15:0]);
        return DATA_WIDTH'(h);
      end
      default: return sh;
    endcase
  endfunction

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      tmo_cnt;
  logic                  kill;
  logic                  buf_vld_p2;

  logic [1:0]            off_p1, size_p1;
  logic                  uns_p1;
  logic [DATA_WIDTH-1:0] addr_p1;
  decoded_instr_t        dec_p1;
  logic [ADDR_WIDTH-1:0] pc_p1;
  logic [DATA_WIDTH-1:0] buf_result_p2;

  logic                  mem_op, misaligned, aligned_op, accept, busy;
  logic                  handshake, rsp_take, mem_done, tmo_hit, complete_now;
  logic [DATA_WIDTH-1:0] result_now;

  assign dmem_req_valid = (state == REQ);

  always_comb begin
    mem_op       = ex_valid && (ex_mem_read || ex_mem_write);
    misaligned   = mem_op && ((ex_mem_size == 2'b01 && ex_alu_result[0]) ||
                              (ex_mem_size[1] && ex_alu_result[1:0] != 2'b00));
    aligned_op   = mem_op && !misaligned;
    accept       = (state == IDLE) && aligned_op && !stall && !flush;
    busy         = (state == REQ) || (state == WAIT_RSP);
    handshake    = (state == REQ) && dmem_req_ready;
    rsp_take     = (state == WAIT_RSP) && dmem_rsp_valid;
    mem_done     = (handshake && dmem_req_we) || rsp_take;
    // Bus progress in the final cycle wins over the abort.
    tmo_hit      = busy && !handshake && !rsp_take && (tmo_cnt >= CNT_LAST);
    complete_now = (mem_done && !stall) || ((state == DONE) && !stall) || tmo_hit;
    // A store reports its effective address as its result.
    result_now   = dmem_req_we ? addr_p1 : load_extend(dmem_rsp_rdata, off_p1, size_p1, uns_p1);

    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = REQ;
      REQ: begin
        if (tmo_hit)        state_nxt = IDLE;
        else if (handshake) state_nxt = dmem_req_we ? (stall ? DONE : IDLE) : WAIT_RSP;
      end
      WAIT_RSP: begin
        if (tmo_hit)       state_nxt = IDLE;
        else if (rsp_take) state_nxt = stall ? DONE : IDLE;
      end
      DONE:     if (flush || !stall) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase

    mem_stall = (state == IDLE) ? (aligned_op && !flush) : !complete_now;
  end

  // ---- p1: request capture / FSM / writeback registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      tmo_cnt        <= '0;
      kill           <= 1'b0;
      buf_vld_p2     <= 1'b0;
      misaligned_exc <= 1'b0;
      timeout_exc    <= 1'b0;
      dmem_req_we    <= 1'b0;
      dmem_req_addr  <= '0;
      dmem_req_wdata <= '0;
      dmem_req_be    <= '0;
      wb_valid       <= 1'b0;
      wb_result      <= '0;
      wb_decoded     <= '0;
      wb_pc          <= '0;
    end else begin
      state          <= state_nxt;
      misaligned_exc <= (state == IDLE) && misaligned && !stall && !flush;
      timeout_exc    <= tmo_hit;

      if (accept)               tmo_cnt <= '0;
      else if (busy && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE)      kill <= 1'b0;
      else if (busy && flush) kill <= 1'b1;

      if (accept) begin
        dmem_req_we    <= ex_mem_write;
        dmem_req_addr  <= {ex_alu_result[ADDR_WIDTH-1:2], 2'b00};
        dmem_req_wdata <= lane_wdata(ex_mem_size, ex_wdata);
        dmem_req_be    <= lane_be(ex_mem_size, ex_alu_result[1:0]);
      end

      if (mem_done && stall) buf_vld_p2 <= !(kill || flush);

      if (state == IDLE) begin
        if (flush) begin
          wb_valid <= 1'b0;
        end else if (!stall) begin
          if (mem_op) begin
            wb_valid <= 1'b0;
          end else begin
            wb_valid   <= ex_valid;
            wb_result  <= ex_alu_result;
            wb_decoded <= ex_decoded;
            wb_pc      <= ex_pc;
          end
        end
      end else if (tmo_hit) begin
        wb_valid <= 1'b0;
      end else if (mem_done && !stall) begin
        wb_valid   <= !(kill || flush);
        wb_result  <= result_now;
        wb_decoded <= dec_p1;
        wb_pc      <= pc_p1;
      end else if ((state == DONE) && !stall && !flush) begin
        wb_valid   <= buf_vld_p2;
        wb_result  <= buf_result_p2;
        wb_decoded <= dec_p1;
        wb_pc      <= pc_p1;
      end
    end
  end

  // ---- p1/p2: latched request fields and parked result ----
  always_ff @(posedge clk) begin
    if (accept) begin
      off_p1  <= ex_alu_result[1:0];
      size_p1 <= ex_mem_size;
      uns_p1  <= ex_mem_unsigned;
      addr_p1 <= ex_alu_result;
      dec_p1  <= ex_decoded;
      pc_p1   <= ex_pc;
    end
    if (mem_done && stall) buf_result_p2 <= result_now;
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: self-checking bench for mem_stage (TIMEOUT_CYCLES = 4).
//   Randomised ALU and memory traffic compared against a behavioural model
//   of lane steering and load extension, plus directed exception, flush,
//   stall and timeout scenarios.

module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           ex_valid;
  logic [DW-1:0]  ex_alu_result;
  logic [DW-1:0]  ex_wdata;
  decoded_instr_t ex_decoded;
  logic [AW-1:0]  ex_pc;
  logic           ex_mem_read;
  logic           ex_mem_write;
  logic [1:0]     ex_mem_size;
  logic           ex_mem_unsigned;
  logic           stall;
  logic           flush;
  logic           dmem_req_valid;
  logic           dmem_req_ready;
  logic           dmem_req_we;
  logic [AW-1:0]  dmem_req_addr;
  logic [DW-1:0]  dmem_req_wdata;
  logic [3:0]     dmem_req_be;
  logic           dmem_rsp_valid;
  logic [DW-1:0]  dmem_rsp_rdata;
  logic [DW-1:0]  wb_result;
  decoded_instr_t wb_decoded;
  logic [AW-1:0]  wb_pc;
  logic           wb_valid;
  logic           mem_stall;
  logic           misaligned_exc;
  logic           timeout_exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_wdata(ex_wdata),
    .ex_decoded(ex_decoded), .ex_pc(ex_pc), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .stall(stall), .flush(flush),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_we(dmem_req_we), .dmem_req_addr(dmem_req_addr),
    .dmem_req_wdata(dmem_req_wdata), .dmem_req_be(dmem_req_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata),
    .wb_result(wb_result), .wb_decoded(wb_decoded), .wb_pc(wb_pc),
    .wb_valid(wb_valid), .mem_stall(mem_stall),
    .misaligned_exc(misaligned_exc), .timeout_exc(timeout_exc)
  );

  // Reference model: byte count per size, enables as a run of ones at the lane.
  function automatic logic [3:0] ref_be(input logic [1:0] size, input int lane);
    int n;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    return 4'(((1 << n) - 1) << lane);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
    if (size == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (size == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic uns,
                                          input int lane, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * lane);
    if (size == 2'd0) begin
      v = v & 32'hFF;
      if (!uns && v >= 32'd128) v = v - 32'd256;
    end else if (size == 2'd1) begin
      v = v & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_alu_result = '0; ex_wdata = '0; ex_decoded = '0; ex_pc = '0;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_mem_size = 2'b00; ex_mem_unsigned = 1'b0;
    stall = 1'b0; flush = 1'b0;
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0;
  endtask

  task automatic drive_alu(input logic [31:0] alu, input logic [31:0] pc, input decoded_instr_t dec);
    ex_valid = 1'b1; ex_alu_result = alu; ex_pc = pc; ex_decoded = dec;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %0b want 0", wb_valid); end
    checks++; if (wb_result !== 32'h0) begin errors++; $display("FAIL reset_wb_result: got %h want 0", wb_result); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0b want 0", dmem_req_valid); end
    checks++; if (dmem_req_be !== 4'h0) begin errors++; $display("FAIL reset_req_be: got %b want 0000", dmem_req_be); end
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_mem_stall: got %0b want 0", mem_stall); end
    checks++; if ({misaligned_exc, timeout_exc} !== 2'b00) begin errors++; $display("FAIL reset_exc: got %b want 00", {misaligned_exc, timeout_exc}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [31:0] alu, pc, hold;
    decoded_instr_t dec;
    for (int i = 0; i < 6; i++) begin
      alu = (i == 0) ? 32'h1234 : $urandom;
      pc  = $urandom;
      dec = 16'($urandom);
      drive_alu(alu, pc, dec);
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL alu_mem_stall[%0d]: got %0b want 0", i, mem_stall); end
      tick();
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid[%0d]: got %0b want 1", i, wb_valid); end
      checks++; if (wb_result !== alu) begin errors++; $display("FAIL alu_wb_result[%0d]: got %h want %h", i, wb_result, alu); end
      checks++; if (wb_pc !== pc) begin errors++; $display("FAIL alu_wb_pc[%0d]: got %h want %h", i, wb_pc, pc); end
      checks++; if (wb_decoded !== dec) begin errors++; $display("FAIL alu_wb_decoded[%0d]: got %h want %h", i, wb_decoded, dec); end
    end
    hold = alu;
    stall = 1'b1;
    drive_alu($urandom | 32'h1, $urandom, 16'($urandom));
    if (ex_alu_result == hold) ex_alu_result = ~hold;
    tick();
    checks++; if (wb_result !== hold) begin errors++; $display("FAIL alu_stall_hold: got %h want %h", wb_result, hold); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_stall_valid: got %0b want 1", wb_valid); end
    stall = 1'b0;
    flush = 1'b1;
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_flush_valid: got %0b want 0", wb_valid); end
    idle_inputs();
    tick();
  endtask

  task automatic test_mem_ops();
    logic        st, uns;
    logic [1:0]  size;
    int          lane, rd, rs;
    logic [31:0] addr, wd, rdata, pc, exp_addr, exp_res;
    decoded_instr_t dec;
    for (int i = 0; i < 16; i++) begin
      pc = $urandom; dec = 16'($urandom); wd = $urandom; rdata = $urandom;
      if (i == 0) begin
        st = 1'b1; size = 2'd0; uns = 1'b0; addr = 32'h103; wd = 32'h0000_00AB; rd = 2; rs = 0;
      end else if (i == 1 || i == 2) begin
        st = 1'b0; size = 2'd1; uns = (i == 2); addr = 32'h202; rdata = 32'h8001_0000; rd = 0; rs = 0;
      end else begin
        st   = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3));
        uns  = 1'($urandom_range(0, 1));
        lane = (size == 2'd0) ? $urandom_range(0, 3) : (size == 2'd1) ? 2 * $urandom_range(0, 1) : 0;
        addr = ($urandom & 32'hFFFF_FFFC) | 32'(lane);
        rd   = st ? $urandom_range(0, 2) : $urandom_range(0, 1);
        rs   = $urandom_range(0, 1);
      end
      lane     = int'(addr & 32'h3);
      exp_addr = addr & 32'hFFFF_FFFC;
      exp_res  = ref_load(size, uns, lane, rdata);

      ex_valid = 1'b1; ex_alu_result = addr; ex_wdata = wd; ex_decoded = dec; ex_pc = pc;
      ex_mem_read = !st; ex_mem_write = st; ex_mem_size = size; ex_mem_unsigned = uns;
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL mem_accept_stall[%0d]: got %0b want 1", i, mem_stall); end
      tick();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;

      for (int c = 0; c <= rd; c++) begin
        dmem_req_ready = (c == rd);
        #1;
        checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("FAIL mem_req_valid[%0d.%0d]: got %0b want 1", i, c, dmem_req_valid); end
        checks++; if (dmem_req_addr !== exp_addr) begin errors++; $display("FAIL mem_req_addr[%0d.%0d]: got %h want %h", i, c, dmem_req_addr, exp_addr); end
        checks++; if (dmem_req_be !== ref_be(size, lane)) begin errors++; $display("FAIL mem_req_be[%0d.%0d]: got %b want %b", i, c, dmem_req_be, ref_be(size, lane)); end
        checks++; if (dmem_req_we !== st) begin errors++; $display("FAIL mem_req_we[%0d.%0d]: got %0b want %0b", i, c, dmem_req_we, st); end
        if (st) begin
          checks++; if (dmem_req_wdata !== ref_wdata(size, wd)) begin errors++; $display("FAIL mem_req_wdata[%0d.%0d]: got %h want %h", i, c, dmem_req_wdata, ref_wdata(size, wd)); end
        end
        checks++; if (mem_stall !== !(st && c == rd)) begin errors++; $display("FAIL mem_req_stall[%0d.%0d]: got %0b want %0b", i, c, mem_stall, !(st && c == rd)); end
        tick();
      end
      dmem_req_ready = 1'b0;

      if (!st) begin
        for (int c = 0; c <= rs; c++) begin
          dmem_rsp_valid = (c == rs);
          dmem_rsp_rdata = (c == rs) ? rdata : $urandom;
          #1;
          checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL mem_wait_req_valid[%0d.%0d]: got %0b want 0", i, c, dmem_req_valid); end
          checks++; if (mem_stall !== (c != rs)) begin errors++; $display("FAIL mem_wait_stall[%0d.%0d]: got %0b want %0b", i, c, mem_stall, (c != rs)); end
          tick();
        end
        dmem_rsp_valid = 1'b0;
        checks++; if (wb_result !== exp_res) begin errors++; $display("FAIL mem_load_result[%0d]: got %h want %h", i, wb_result, exp_res); end
      end
      checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mem_wb_valid[%0d]: got %0b want 1", i, wb_valid); end
      checks++; if (wb_pc !== pc) begin errors++; $display("FAIL mem_wb_pc[%0d]: got %h want %h", i, wb_pc, pc); end
      checks++; if (wb_decoded !== dec) begin errors++; $display("FAIL mem_wb_decoded[%0d]: got %h want %h", i, wb_decoded, dec); end
      checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL mem_req_idle[%0d]: got %0b want 0", i, dmem_req_valid); end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_misaligned();
    logic [31:0] addr;
    for (int i = 0; i < 2; i++) begin
      drive_alu($urandom, $urandom, 16'($urandom));
      tick();
      addr = (i == 0) ? 32'h201 : (($urandom & 32'hFFFF_FFFC) | 32'h3);
      ex_valid = 1'b1; ex_alu_result = addr; ex_mem_read = (i == 0); ex_mem_write = (i != 0);
      ex_mem_size = (i == 0) ? 2'b10 : 2'b01;
      #1;
      checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall[%0d]: got %0b want 0", i, mem_stall); end
      tick();
      ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
      checks++; if (misaligned_exc !== 1'b1) begin errors++; $display("FAIL mis_exc[%0d]: got %0b want 1", i, misaligned_exc); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mis_wb_valid[%0d]: got %0b want 0", i, wb_valid); end
      checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_req_valid[%0d]: got %0b want 0", i, dmem_req_valid); end
      tick();
      checks++; if (misaligned_exc !== 1'b0) begin errors++; $display("FAIL mis_exc_pulse[%0d]: got %0b want 0", i, misaligned_exc); end
      checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL mis_req_later[%0d]: got %0b want 0", i, dmem_req_valid); end
    end
    idle_inputs();
  endtask

  task automatic test_flush_wait();
    logic [31:0] alu;
    ex_valid = 1'b1; ex_alu_result = 32'h300; ex_mem_read = 1'b1; ex_mem_size = 2'b10;
    tick();
    idle_inputs();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL flush_wait_stall: got %0b want 1", mem_stall); end
    tick();
    flush = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = $urandom;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL flush_rsp_stall: got %0b want 0", mem_stall); end
    tick();
    dmem_rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL flush_wb_valid: got %0b want 0", wb_valid); end
    alu = $urandom;
    drive_alu(alu, $urandom, 16'($urandom));
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL flush_idle_stall: got %0b want 0", mem_stall); end
    tick();
    checks++; if (wb_result !== alu) begin errors++; $display("FAIL flush_next_alu: got %h want %h", wb_result, alu); end
    idle_inputs();
    tick();
  endtask

  task automatic test_stall_done();
    logic [31:0] rdata, exp_res;
    rdata   = $urandom | 32'h0000_8000;
    exp_res = ref_load(2'd0, 1'b0, 1, rdata);
    ex_valid = 1'b1; ex_alu_result = 32'h401; ex_mem_read = 1'b1; ex_mem_size = 2'b00;
    tick();
    idle_inputs();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    stall = 1'b1;
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = rdata;
    #1;
    checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL done_rsp_stall: got %0b want 1", mem_stall); end
    tick();
    dmem_rsp_valid = 1'b0; dmem_rsp_rdata = ~rdata;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL done_hold_stall[%0d]: got %0b want 1", k, mem_stall); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL done_hold_wb[%0d]: got %0b want 0", k, wb_valid); end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL done_release_stall: got %0b want 0", mem_stall); end
    tick();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL done_wb_valid: got %0b want 1", wb_valid); end
    checks++; if (wb_result !== exp_res) begin errors++; $display("FAIL done_wb_result: got %h want %h", wb_result, exp_res); end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    logic [31:0] alu;
    ex_valid = 1'b1; ex_alu_result = 32'h500; ex_mem_read = 1'b1; ex_mem_size = 2'b10;
    tick();
    idle_inputs();
    for (int c = 0; c < TMO; c++) begin
      #1;
      checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("FAIL tmo_req_valid[%0d]: got %0b want 1", c, dmem_req_valid); end
      checks++; if (timeout_exc !== 1'b0) begin errors++; $display("FAIL tmo_early_exc[%0d]: got %0b want 0", c, timeout_exc); end
      checks++; if (mem_stall !== (c < TMO - 1)) begin errors++; $display("FAIL tmo_stall[%0d]: got %0b want %0b", c, mem_stall, (c < TMO - 1)); end
      tick();
    end
    checks++; if (timeout_exc !== 1'b1) begin errors++; $display("FAIL tmo_exc: got %0b want 1", timeout_exc); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL tmo_req_drop: got %0b want 0", dmem_req_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL tmo_wb_valid: got %0b want 0", wb_valid); end
    dmem_rsp_valid = 1'b1; dmem_rsp_rdata = $urandom;
    #1;
    checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL tmo_stray_stall: got %0b want 0", mem_stall); end
    tick();
    dmem_rsp_valid = 1'b0;
    checks++; if (timeout_exc !== 1'b0) begin errors++; $display("FAIL tmo_exc_pulse: got %0b want 0", timeout_exc); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL tmo_stray_wb: got %0b want 0", wb_valid); end
    alu = $urandom;
    drive_alu(alu, $urandom, 16'($urandom));
    tick();
    checks++; if (wb_result !== alu || wb_valid !== 1'b1) begin errors++; $display("FAIL tmo_idle_alu: got %h/%0b want %h/1", wb_result, wb_valid, alu); end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_ops();
    test_misaligned();
    test_flush_wait();
    test_stall_done();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
